// File: rtl/arb_defs.sv
// Shared arbiter definitions: FSM state encoding and hold-counter width.
package arb_defs;
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e grant_of(input logic who);
    return who ? GRANT1 : GRANT0;
  endfunction
endpackage

// File: rtl/hold_counter.sv
// Saturating tenure counter: clears on clr, counts up on en, sticks at MAX-1.
module hold_counter
  import arb_defs::*;
#(
  parameter int MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [HOLD_CNT_W-1:0] count
);
  localparam logic [HOLD_CNT_W-1:0] TOP = HOLD_CNT_W'(MAX - 1);

  logic [HOLD_CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr)               count_q <= '0;
    else if (en && count_q != TOP) count_q <= count_q + HOLD_CNT_W'(1);
  end

  assign count = count_q;
endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter for a shared 2:1 path with bounded tenure.
module mux_sel_arbiter
  import arb_defs::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy
);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic                  sel_q, sel_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  hold_exp;

  assign hold_exp = (hold_cnt == HOLD_LAST);

  hold_counter #(.MAX(MAX_HOLD)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state_q),
    .en   (state_q != IDLE),
    .count(hold_cnt)
  );

  // last=1 out of reset so that req0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = grant_of(~last_q);
        else if (req0)    state_d = GRANT0;
        else if (req1)    state_d = GRANT1;
      end
      GRANT0: begin
        if (!req0)                state_d = req1 ? GRANT1 : IDLE;
        else if (req1 && hold_exp) state_d = GRANT1;
      end
      GRANT1: begin
        if (!req1)                state_d = req0 ? GRANT0 : IDLE;
        else if (req0 && hold_exp) state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant flops mirror the next state so outputs leave straight from flops
  always_comb begin
    gnt0_d = (state_d == GRANT0);
    gnt1_d = (state_d == GRANT1);
    last_d = last_q;
    sel_d  = sel_q;
    if (state_d != state_q && state_d != IDLE) begin
      last_d = (state_d == GRANT1);
      sel_d  = (state_d == GRANT1);
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign sel  = sel_q;
  assign busy = gnt0_q | gnt1_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench: vector table, directed corner sequences, and random traffic vs. an owner/tenure model.
module tb_mux_sel_arbiter;
  logic clk = 1'b0;
  logic rst, req0, req1;
  logic g0_8, g1_8, sel_8, busy_8;
  logic g0_1, g1_1, sel_1, busy_1;

  int n_tests = 0;
  int n_fail  = 0;
  int w0_8 = 0, w1_8 = 0, w0_1 = 0, w1_1 = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .gnt0(g0_8), .gnt1(g1_8), .sel(sel_8), .busy(busy_8)
  );

  mux_sel_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .gnt0(g0_1), .gnt1(g1_1), .sel(sel_1), .busy(busy_1)
  );

  // owner: -1 none, 0/1 requester; tenure: cycles the owner has held so far
  typedef struct packed {
    int owner;
    int tenure;
    int last;
    int sel;
  } mdl_t;

  typedef struct packed {
    bit         rst;
    bit         r0;
    bit         r1;
    logic [3:0] exp;   // {gnt0, gnt1, sel, busy}
  } vec_t;

  mdl_t m8, m1;

  function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit a, input bit b, input int mh);
    mdl_t n;
    int   nxt;
    bit   mine, oth;
    n = m;
    if (r) begin
      n.owner = -1; n.tenure = 0; n.last = 1; n.sel = 0;
      return n;
    end
    mine = (m.owner == 0) ? a : b;
    oth  = (m.owner == 0) ? b : a;
    if (m.owner < 0) begin
      if (a && b)  nxt = 1 - m.last;
      else if (a)  nxt = 0;
      else if (b)  nxt = 1;
      else         nxt = -1;
    end else if (!mine)             nxt = oth ? 1 - m.owner : -1;
    else if (oth && m.tenure >= mh) nxt = 1 - m.owner;
    else                            nxt = m.owner;
    if (nxt != m.owner) begin
      n.tenure = (nxt >= 0) ? 1 : 0;
      if (nxt >= 0) begin n.last = nxt; n.sel = nxt; end
    end else if (nxt >= 0) n.tenure = m.tenure + 1;
    n.owner = nxt;
    return n;
  endfunction

  function automatic logic [3:0] exp_of(input mdl_t m);
    return {m.owner == 0, m.owner == 1, m.sel == 1, m.owner >= 0};
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {g0,g1,sel,busy}=%b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_wait(input string nm, input int w, input int lim);
    n_tests++;
    if (w > lim) begin
      n_fail++;
      $display("FAIL %s: waited %0d cycles, limit %0d", nm, w, lim);
    end
  endtask

  // One clock: drive on negedge, step models on posedge, sample #1 later
  task automatic cyc(input bit r, input bit a, input bit b);
    @(negedge clk);
    rst = r; req0 = a; req1 = b;
    @(posedge clk);
    m8 = mdl_step(m8, r, a, b, 8);
    m1 = mdl_step(m1, r, a, b, 1);
    #1;
    chk("model_mh8", {g0_8, g1_8, sel_8, busy_8}, exp_of(m8));
    chk("model_mh1", {g0_1, g1_1, sel_1, busy_1}, exp_of(m1));
    chk("mutex_mh8", {1'b0, 1'b0, 1'b0, g0_8 & g1_8}, 4'b0000);
    chk("mutex_mh1", {1'b0, 1'b0, 1'b0, g0_1 & g1_1}, 4'b0000);
  endtask

  function automatic int nxt_wait(input int w, input bit r, input bit req, input bit g);
    if (r || g || !req) return 0;
    return w + 1;
  endfunction

  initial begin
    vec_t tbl [13];
    logic [3:0] v8, v1;
    bit a, b, r;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'b1001};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b0111};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'b0111};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'b0010};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'b1001};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'b0111};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'b1001};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'b1001};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'b0000};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 4'b1001};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'b0000};

    m8 = '{-1, 0, 1, 0};
    m1 = '{-1, 0, 1, 0};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rst, tbl[i].r0, tbl[i].r1);
      chk($sformatf("vec%0d", i), {g0_8, g1_8, sel_8, busy_8}, tbl[i].exp);
    end

    // Tie from reset: 8 cycles each, alternating; MAX_HOLD=1 alternates every cycle
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      cyc(1'b0, 1'b1, 1'b1);
      v8 = (((k - 1) / 8) % 2 == 0) ? 4'b1001 : 4'b0111;
      v1 = (k % 2 == 1) ? 4'b1001 : 4'b0111;
      chk($sformatf("tie8_k%0d", k), {g0_8, g1_8, sel_8, busy_8}, v8);
      chk($sformatf("tie1_k%0d", k), {g0_1, g1_1, sel_1, busy_1}, v1);
    end

    // Lone req0 for 20 cycles, then req1 arrives against a saturated counter
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("solo_k%0d", k), {g0_8, g1_8, sel_8, busy_8}, 4'b1001);
    end
    cyc(1'b0, 1'b1, 1'b1);
    chk("sat_handover", {g0_8, g1_8, sel_8, busy_8}, 4'b0111);

    // gnt1 -> gnt0 direct handover when req1 drops
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ho_g1", {g0_8, g1_8, sel_8, busy_8}, 4'b0111);
    cyc(1'b0, 1'b1, 1'b1);
    chk("ho_hold", {g0_8, g1_8, sel_8, busy_8}, 4'b0111);
    cyc(1'b0, 1'b1, 1'b0);
    chk("ho_g0", {g0_8, g1_8, sel_8, busy_8}, 4'b1001);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ho_idle", {g0_8, g1_8, sel_8, busy_8}, 4'b0000);

    // Reset pulse during GRANT1
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("rp_g1", {g0_8, g1_8, sel_8, busy_8}, 4'b0111);
    cyc(1'b1, 1'b0, 1'b1);
    chk("rp_drop", {g0_8, g1_8, sel_8, busy_8}, 4'b0000);
    cyc(1'b0, 1'b1, 1'b1);
    chk("rp_tie", {g0_8, g1_8, sel_8, busy_8}, 4'b1001);

    // Random sticky requests with occasional reset
    a = 1'b0; b = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      r = ($urandom_range(0, 299) == 0);
      cyc(r, a, b);
      w0_8 = nxt_wait(w0_8, r, a, g0_8);
      w1_8 = nxt_wait(w1_8, r, b, g1_8);
      w0_1 = nxt_wait(w0_1, r, a, g0_1);
      w1_1 = nxt_wait(w1_1, r, b, g1_1);
      chk_wait("wait0_mh8", w0_8, 9);
      chk_wait("wait1_mh8", w1_8, 9);
      chk_wait("wait0_mh1", w0_1, 2);
      chk_wait("wait1_mh1", w1_1, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
